// File: rtl/i2c_cfg_target.sv
`timescale 1ns/1ps
// i2c_cfg_target: I2C target holding the CIC/FIR configuration register file.
// Oversamples the open-drain bus with clk (>= 16x SCL), decodes START/STOP,
// address, pointer and data bytes, and drives sdata low for ACK / read data.
// No clock stretching.
module i2c_cfg_target #(
    parameter logic [6:0] I2C_ADDR = 7'h2A,
    parameter int         DEC_W    = 2,
    parameter int         DATA_W   = 8,
    parameter logic [7:0] ID_VALUE = 8'hA5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     scl_in,
    input  logic                     sda_in,
    output logic                     sda_oe,
    output logic                     cic_enable,
    output logic                     fir_enable,
    output logic                     clear,
    output logic [DEC_W-1:0]         filter_dec_factor,
    output logic signed [DATA_W-1:0] coef0,
    output logic signed [DATA_W-1:0] coef1,
    output logic signed [DATA_W-1:0] coef2,
    output logic signed [DATA_W-1:0] div,
    output logic                     busy
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ACK_ADDR,
        ST_RX_PTR,
        ST_RX_DATA,
        ST_ACK_RX,
        ST_TX,
        ST_ACK_TX,
        ST_WAIT_STOP
    } state_t;

    // ------------------------------------------------------------------
    // Input conditioning: bit 0 = scl, bit 1 = sda
    // ------------------------------------------------------------------
    logic [1:0] line_in;
    logic [1:0] line_sync;
    logic [1:0] line_hist;

    assign line_in = {sda_in, scl_in};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;
            logic hist_reg;

            // Two-flop synchronizer plus one history flop; idle bus level is 1
            always_ff @(posedge clk) begin
                if (reset) begin
                    meta_reg <= 1'b1;
                    sync_reg <= 1'b1;
                    hist_reg <= 1'b1;
                end else begin
                    meta_reg <= line_in[gi];
                    sync_reg <= meta_reg;
                    hist_reg <= sync_reg;
                end
            end

            assign line_sync[gi] = sync_reg;
            assign line_hist[gi] = hist_reg;
        end
    endgenerate

    logic scl_s, scl_h, sda_s, sda_h;
    logic scl_rise, scl_fall, start_det, stop_det;

    assign scl_s     = line_sync[0];
    assign scl_h     = line_hist[0];
    assign sda_s     = line_sync[1];
    assign sda_h     = line_hist[1];
    assign scl_rise  = scl_s & ~scl_h;
    assign scl_fall  = ~scl_s & scl_h;
    assign start_det = scl_s & scl_h & sda_h & ~sda_s;
    assign stop_det  = scl_s & scl_h & ~sda_h & sda_s;

    // ------------------------------------------------------------------
    // Protocol state
    // ------------------------------------------------------------------
    state_t     state_reg, state_next;
    logic [3:0] bit_cnt_reg, bit_cnt_next;
    logic [7:0] shift_reg, shift_next;
    logic [7:0] tx_reg, tx_next;
    logic [7:0] pointer_reg, pointer_next;
    logic       sda_oe_reg, sda_oe_next;
    logic       busy_reg, busy_next;
    logic       rw_reg, rw_next;
    logic       ack_reg, ack_next;
    // A received byte is committed on the clk after its 8th rising edge
    logic       commit_reg, commit_next;
    logic       commit_ptr_reg, commit_ptr_next;

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic                     cic_reg, fir_reg, clear_reg;
    logic [DEC_W-1:0]         dec_reg;
    logic signed [DATA_W-1:0] coef0_reg, coef1_reg, coef2_reg, div_reg;
    logic [7:0]               read_data;

    // Read multiplexer addressed by the pointer; unmapped addresses read 0
    always_comb begin
        read_data = 8'h00;
        case (pointer_reg)
            8'h00:   read_data = {6'b0, fir_reg, cic_reg};
            8'h01:   read_data = {{(8 - DEC_W){1'b0}}, dec_reg};
            8'h02:   read_data = coef0_reg;
            8'h03:   read_data = coef1_reg;
            8'h04:   read_data = coef2_reg;
            8'h05:   read_data = div_reg;
            8'h06:   read_data = ID_VALUE;
            default: read_data = 8'h00;
        endcase
    end

    // Protocol state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            bit_cnt_reg    <= 4'd0;
            shift_reg      <= 8'h00;
            tx_reg         <= 8'h00;
            pointer_reg    <= 8'h00;
            sda_oe_reg     <= 1'b0;
            busy_reg       <= 1'b0;
            rw_reg         <= 1'b0;
            ack_reg        <= 1'b1;
            commit_reg     <= 1'b0;
            commit_ptr_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            bit_cnt_reg    <= bit_cnt_next;
            shift_reg      <= shift_next;
            tx_reg         <= tx_next;
            pointer_reg    <= pointer_next;
            sda_oe_reg     <= sda_oe_next;
            busy_reg       <= busy_next;
            rw_reg         <= rw_next;
            ack_reg        <= ack_next;
            commit_reg     <= commit_next;
            commit_ptr_reg <= commit_ptr_next;
        end
    end

    // Next-state logic: START/STOP take priority over every state
    always_comb begin
        state_next      = state_reg;
        bit_cnt_next    = bit_cnt_reg;
        shift_next      = shift_reg;
        tx_next         = tx_reg;
        pointer_next    = pointer_reg;
        sda_oe_next     = sda_oe_reg;
        busy_next       = busy_reg;
        rw_next         = rw_reg;
        ack_next        = ack_reg;
        commit_next     = 1'b0;
        commit_ptr_next = commit_ptr_reg;

        // Pointer byte loads the pointer; data byte advances it after writing
        if (commit_reg) begin
            pointer_next = commit_ptr_reg ? shift_reg : pointer_reg + 8'd1;
        end

        if (start_det) begin
            state_next   = ST_ADDR;
            bit_cnt_next = 4'd0;
            sda_oe_next  = 1'b0;
        end else if (stop_det) begin
            state_next  = ST_IDLE;
            sda_oe_next = 1'b0;
            busy_next   = 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                end

                ST_ADDR: begin
                    if (scl_rise && bit_cnt_reg < 4'd8) begin
                        shift_next   = {shift_reg[6:0], sda_s};
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                    end else if (scl_fall && bit_cnt_reg == 4'd8) begin
                        if (shift_reg[7:1] == I2C_ADDR) begin
                            state_next  = ST_ACK_ADDR;
                            sda_oe_next = 1'b1;
                            busy_next   = 1'b1;
                            rw_next     = shift_reg[0];
                        end else begin
                            state_next  = ST_IDLE;
                            sda_oe_next = 1'b0;
                            busy_next   = 1'b0;
                        end
                    end
                end

                ST_ACK_ADDR: begin
                    if (scl_fall) begin
                        bit_cnt_next = 4'd0;
                        if (rw_reg) begin
                            state_next  = ST_TX;
                            tx_next     = read_data;
                            sda_oe_next = ~read_data[7];
                        end else begin
                            state_next  = ST_RX_PTR;
                            sda_oe_next = 1'b0;
                        end
                    end
                end

                ST_RX_PTR, ST_RX_DATA: begin
                    if (scl_rise && bit_cnt_reg < 4'd8) begin
                        shift_next   = {shift_reg[6:0], sda_s};
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                        if (bit_cnt_reg == 4'd7) begin
                            commit_next     = 1'b1;
                            commit_ptr_next = (state_reg == ST_RX_PTR);
                        end
                    end else if (scl_fall && bit_cnt_reg == 4'd8) begin
                        state_next  = ST_ACK_RX;
                        sda_oe_next = 1'b1;
                    end
                end

                ST_ACK_RX: begin
                    // Entered on a falling edge, so the next fall ends the ACK slot
                    if (scl_fall) begin
                        state_next   = ST_RX_DATA;
                        sda_oe_next  = 1'b0;
                        bit_cnt_next = 4'd0;
                    end
                end

                ST_TX: begin
                    if (scl_rise && bit_cnt_reg < 4'd8) begin
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_reg == 4'd8) begin
                            state_next   = ST_ACK_TX;
                            sda_oe_next  = 1'b0;
                            pointer_next = pointer_reg + 8'd1;
                        end else begin
                            tx_next     = {tx_reg[6:0], 1'b0};
                            sda_oe_next = ~tx_reg[6];
                        end
                    end
                end

                ST_ACK_TX: begin
                    if (scl_rise) begin
                        ack_next = sda_s;
                    end else if (scl_fall) begin
                        if (!ack_reg) begin
                            state_next   = ST_TX;
                            bit_cnt_next = 4'd0;
                            tx_next      = read_data;
                            sda_oe_next  = ~read_data[7];
                        end else begin
                            state_next  = ST_WAIT_STOP;
                            sda_oe_next = 1'b0;
                            busy_next   = 1'b0;
                        end
                    end
                end

                ST_WAIT_STOP: begin
                end

                default: begin
                    state_next  = ST_IDLE;
                    sda_oe_next = 1'b0;
                    busy_next   = 1'b0;
                end
            endcase
        end
    end

    // Register writes; clear pulses on the same cycle the CTRL write lands
    always_ff @(posedge clk) begin
        if (reset) begin
            cic_reg   <= 1'b0;
            fir_reg   <= 1'b0;
            clear_reg <= 1'b0;
            dec_reg   <= '0;
            coef0_reg <= '0;
            coef1_reg <= '0;
            coef2_reg <= '0;
            div_reg   <= 8'h01;
        end else begin
            clear_reg <= 1'b0;
            if (commit_reg && !commit_ptr_reg) begin
                case (pointer_reg)
                    8'h00: begin
                        cic_reg   <= shift_reg[0];
                        fir_reg   <= shift_reg[1];
                        clear_reg <= shift_reg[2];
                    end
                    8'h01:   dec_reg   <= shift_reg[DEC_W-1:0];
                    8'h02:   coef0_reg <= shift_reg;
                    8'h03:   coef1_reg <= shift_reg;
                    8'h04:   coef2_reg <= shift_reg;
                    8'h05:   div_reg   <= shift_reg;
                    default: begin
                    end
                endcase
            end
        end
    end

    assign sda_oe            = sda_oe_reg;
    assign busy              = busy_reg;
    assign cic_enable        = cic_reg;
    assign fir_enable        = fir_reg;
    assign clear             = clear_reg;
    assign filter_dec_factor = dec_reg;
    assign coef0             = coef0_reg;
    assign coef1             = coef1_reg;
    assign coef2             = coef2_reg;
    assign div               = div_reg;

endmodule

// File: tb/tb_i2c_cfg_target.sv
`timescale 1ns/1ps
// Testbench for i2c_cfg_target: bit-banged I2C initiator plus a byte-level
// register-map model; directed scenarios followed by random transactions.
module tb_i2c_cfg_target;

    localparam int Q = 60;  // quarter SCL period in ns (SCL = 24 clk periods)

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              scl = 1'b1;
    logic              sda_drv = 1'b1;
    logic              sda_line;
    logic              sda_oe, cic_enable, fir_enable, clear, busy;
    logic [1:0]        filter_dec_factor;
    logic signed [7:0] coef0, coef1, coef2, div;

    assign sda_line = sda_drv & ~sda_oe;

    i2c_cfg_target dut (
        .clk               (clk),
        .reset             (reset),
        .scl_in            (scl),
        .sda_in            (sda_line),
        .sda_oe            (sda_oe),
        .cic_enable        (cic_enable),
        .fir_enable        (fir_enable),
        .clear             (clear),
        .filter_dec_factor (filter_dec_factor),
        .coef0             (coef0),
        .coef1             (coef1),
        .coef2             (coef2),
        .div               (div),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // bus activity monitors (only ever accumulate)
    int clear_cycles = 0;
    int clear_cic1   = 0;
    int oe_cycles    = 0;
    int busy_cycles  = 0;

    always @(negedge clk) begin
        if (clear) begin
            clear_cycles++;
            if (cic_enable) clear_cic1++;
        end
        if (sda_oe) oe_cycles++;
        if (busy) busy_cycles++;
    end

    // reference model of the register map
    logic       m_cic, m_fir;
    logic [1:0] m_dec;
    logic [7:0] m_coef0, m_coef1, m_coef2, m_div, m_ptr;
    int         m_clear_cnt = 0;

    logic [7:0] wr_data [0:7];
    logic [7:0] rd_data [0:7];

    task automatic model_reset();
        m_cic = 0; m_fir = 0; m_dec = 0;
        m_coef0 = 0; m_coef1 = 0; m_coef2 = 0; m_div = 8'h01; m_ptr = 0;
    endtask

    task automatic model_write(input logic [7:0] d);
        case (m_ptr)
            8'h00: begin m_cic = d[0]; m_fir = d[1]; if (d[2]) m_clear_cnt++; end
            8'h01: m_dec = d[1:0];
            8'h02: m_coef0 = d;
            8'h03: m_coef1 = d;
            8'h04: m_coef2 = d;
            8'h05: m_div = d;
            default: ;
        endcase
        m_ptr = m_ptr + 8'd1;
    endtask

    task automatic model_read(output logic [7:0] d);
        case (m_ptr)
            8'h00: d = {6'b0, m_fir, m_cic};
            8'h01: d = {6'b0, m_dec};
            8'h02: d = m_coef0;
            8'h03: d = m_coef1;
            8'h04: d = m_coef2;
            8'h05: d = m_div;
            8'h06: d = 8'hA5;
            default: d = 8'h00;
        endcase
        m_ptr = m_ptr + 8'd1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_cic"},   {31'b0, cic_enable}, {31'b0, m_cic});
        check({tag, "_fir"},   {31'b0, fir_enable}, {31'b0, m_fir});
        check({tag, "_dec"},   {30'b0, filter_dec_factor}, {30'b0, m_dec});
        check({tag, "_coef0"}, {24'b0, $unsigned(coef0)}, {24'b0, m_coef0});
        check({tag, "_coef1"}, {24'b0, $unsigned(coef1)}, {24'b0, m_coef1});
        check({tag, "_coef2"}, {24'b0, $unsigned(coef2)}, {24'b0, m_coef2});
        check({tag, "_div"},   {24'b0, $unsigned(div)},   {24'b0, m_div});
        check({tag, "_clears"}, clear_cycles, m_clear_cnt);
    endtask

    // bit-level initiator
    task automatic i2c_start();
        sda_drv = 1'b1; #Q; scl = 1'b1; #Q; sda_drv = 1'b0; #Q; scl = 1'b0; #Q;
    endtask

    task automatic i2c_stop();
        sda_drv = 1'b0; #Q; scl = 1'b1; #Q; sda_drv = 1'b1; #Q;
    endtask

    task automatic write_bit(input logic b);
        sda_drv = b; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
    endtask

    task automatic read_bit(output logic b);
        sda_drv = 1'b1; #Q; scl = 1'b1; #Q; b = sda_line; #Q; scl = 1'b0; #Q;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(nack);
    endtask

    // transaction-level operations
    task automatic do_write(input logic [7:0] ptr, input int n);
        logic ack;
        i2c_start();
        write_byte(8'h54, ack);
        check("wr_addr_ack", {31'b0, ack}, 32'd0);
        check("wr_busy", {31'b0, busy}, 32'd1);
        write_byte(ptr, ack);
        check("wr_ptr_ack", {31'b0, ack}, 32'd0);
        m_ptr = ptr;
        for (int i = 0; i < n; i++) begin
            write_byte(wr_data[i], ack);
            check("wr_data_ack", {31'b0, ack}, 32'd0);
            model_write(wr_data[i]);
        end
        i2c_stop();
        check("wr_busy_after_stop", {31'b0, busy}, 32'd0);
        $display("WRITE ptr=%02h bytes=%0d first=%02h", ptr, n, wr_data[0]);
        check_outputs("wr");
    endtask

    task automatic do_read(input logic [7:0] ptr, input int n);
        logic ack;
        logic [7:0] exp;
        i2c_start();
        write_byte(8'h54, ack);
        check("rd_addr_ack", {31'b0, ack}, 32'd0);
        write_byte(ptr, ack);
        check("rd_ptr_ack", {31'b0, ack}, 32'd0);
        m_ptr = ptr;
        i2c_start();
        write_byte(8'h55, ack);
        check("rd_raddr_ack", {31'b0, ack}, 32'd0);
        for (int i = 0; i < n; i++) begin
            read_byte(i == n - 1, rd_data[i]);
            model_read(exp);
            check("rd_data", {24'b0, rd_data[i]}, {24'b0, exp});
        end
        check("rd_oe_after_nack", {31'b0, sda_oe}, 32'd0);
        check("rd_busy_after_nack", {31'b0, busy}, 32'd0);
        i2c_stop();
        $display("READ  ptr=%02h bytes=%0d first=%02h", ptr, n, rd_data[0]);
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ack;
        int oe0, busy0, clr0, clc0, n;
        logic [7:0] ptr;
        model_reset();
        #42;
        reset = 1'b0;
        #20;

        // reset state
        check("rst_sda_oe", {31'b0, sda_oe}, 32'd0);
        check("rst_busy",   {31'b0, busy},   32'd0);
        check("rst_clear",  {31'b0, clear},  32'd0);
        check("rst_div_const", {24'b0, $unsigned(div)}, 32'h01);
        check_outputs("rst");

        // wrong address: never acknowledged, never busy
        oe0 = oe_cycles; busy0 = busy_cycles;
        i2c_start();
        write_byte(8'h60, ack);
        check("badaddr_nack", {31'b0, ack}, 32'd1);
        write_byte(8'hFF, ack);
        check("badaddr_byte_nack", {31'b0, ack}, 32'd1);
        i2c_stop();
        $display("WRITE addr=30 (mismatch)");
        check("badaddr_oe_never", oe_cycles - oe0, 32'd0);
        check("badaddr_busy_never", busy_cycles - busy0, 32'd0);
        check_outputs("badaddr");

        // coefficient burst write
        wr_data[0] = 8'h11; wr_data[1] = 8'h22; wr_data[2] = 8'h33;
        do_write(8'h02, 3);
        check("coef0_const", {24'b0, $unsigned(coef0)}, 32'h11);
        check("coef2_const", {24'b0, $unsigned(coef2)}, 32'h33);

        // ID read then unmapped read, ACK then NACK
        do_read(8'h06, 2);
        check("id_const", {24'b0, rd_data[0]}, 32'hA5);
        check("unmapped_const", {24'b0, rd_data[1]}, 32'h00);

        // CTRL write with clear pulse, DEC write with upper bits ignored
        clr0 = clear_cycles; clc0 = clear_cic1;
        wr_data[0] = 8'h07;
        do_write(8'h00, 1);
        check("clear_width", clear_cycles - clr0, 32'd1);
        check("clear_with_ctrl", clear_cic1 - clc0, 32'd1);
        do_read(8'h00, 1);
        check("ctrl_readback", {24'b0, rd_data[0]}, 32'h03);
        wr_data[0] = 8'hFF;
        do_write(8'h01, 1);
        check("dec_const", {30'b0, filter_dec_factor}, 32'd3);
        do_read(8'h01, 1);
        check("dec_readback", {24'b0, rd_data[0]}, 32'h03);

        // partial byte after the pointer, then STOP: discarded
        i2c_start();
        write_byte(8'h54, ack);
        check("partial_addr_ack", {31'b0, ack}, 32'd0);
        write_byte(8'h05, ack);
        check("partial_ptr_ack", {31'b0, ack}, 32'd0);
        m_ptr = 8'h05;
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
        i2c_stop();
        $display("WRITE ptr=05 partial 4 bits");
        check("partial_busy", {31'b0, busy}, 32'd0);
        check_outputs("partial");
        do_read(8'h05, 1);
        check("partial_div_readback", {24'b0, rd_data[0]}, 32'h01);

        // pointer wraps from 0xFF to CTRL
        wr_data[0] = 8'h33; wr_data[1] = 8'h44; wr_data[2] = 8'h05;
        do_write(8'hFE, 3);

        // random transactions against the model
        for (int t = 0; t < 16; t++) begin
            ptr = 8'($urandom_range(0, 8));
            n = $urandom_range(1, 3);
            if ($urandom_range(0, 1) == 0) begin
                for (int i = 0; i < n; i++) wr_data[i] = 8'($urandom);
                do_write(ptr, n);
            end else begin
                do_read(ptr, n);
            end
        end

        // reset while acknowledging the address
        i2c_start();
        for (int i = 7; i >= 0; i--) write_bit(i[0] ? 1'b0 : ((8'h54 >> i) & 8'h01) != 0);
        check("ack_before_reset_oe", {31'b0, sda_oe}, 32'd1);
        check("ack_before_reset_busy", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        #10;
        reset = 1'b0;
        $display("RESET during address ACK");
        model_reset();
        check("midrst_sda_oe", {31'b0, sda_oe}, 32'd0);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check_outputs("midrst");
        wr_data[0] = 8'h5A; wr_data[1] = 8'h80;
        do_write(8'h04, 2);
        do_read(8'h04, 2);
        check("post_reset_div", {24'b0, rd_data[1]}, 32'h80);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
